// File: rtl/fwd_hazard_ctrl_if.sv
// Hazard-controller interface: D-stage operand/producer info, MDU issue, and
// the forward-select / stall results returned to the pipeline.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned NREAD = 2,
    parameter int unsigned TW    = 3
);
    logic                  D_valid;
    logic [NREAD*5-1:0]    D_src;
    logic [NREAD*TW-1:0]   D_tuse;
    logic [4:0]            D_dst;
    logic [TW-1:0]         D_tnew;
    logic                  D_is_md;
    logic                  E_md_start;
    logic                  E_md_is_div;
    logic                  stall;
    logic [NREAD*2-1:0]    D_fsel;
    logic [NREAD*2-1:0]    E_fsel;
    logic                  md_busy;

    modport master (
        output D_valid, D_src, D_tuse, D_dst, D_tnew, D_is_md, E_md_start, E_md_is_div,
        input  stall, D_fsel, E_fsel, md_busy
    );

    modport slave (
        input  D_valid, D_src, D_tuse, D_dst, D_tnew, D_is_md, E_md_start, E_md_is_div,
        output stall, D_fsel, E_fsel, md_busy
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and stall controller: shadows E/M/W producer records,
// picks the nearest ready producer per read port, and interlocks on the MDU.
module fwd_hazard_ctrl #(
    parameter int unsigned NREAD    = 2,
    parameter int unsigned TW       = 3,
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    fwd_hazard_ctrl_if.slave hz
);
    localparam int unsigned CMAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    logic                r_e_valid, r_m_valid, r_w_valid;
    logic [4:0]          r_e_dst, r_m_dst, r_w_dst;
    logic [TW-1:0]       r_e_tnew, r_m_tnew, r_w_tnew;
    logic [NREAD*5-1:0]  r_e_src;
    logic [CW-1:0]       r_md_cnt;

    logic [NREAD-1:0]    w_stall_req;
    logic [NREAD*2-1:0]  w_d_fsel;
    logic [NREAD*2-1:0]  w_e_fsel;
    logic                w_e_viol;
    logic                w_md_busy;

    function automatic logic hit(input logic v, input logic [4:0] dst, input logic [4:0] src);
        return v && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    always_comb begin
        logic [4:0]    w_src;
        logic [TW-1:0] w_tuse;
        logic [TW-1:0] w_tn;
        logic [1:0]    w_sel;
        logic          w_hit;
        w_stall_req = '0;
        w_d_fsel    = '0;
        w_e_fsel    = '0;
        w_e_viol    = 1'b0;
        w_src       = '0;
        w_tuse      = '0;
        w_tn        = '0;
        w_sel       = '0;
        w_hit       = 1'b0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            w_src  = hz.D_src[5*p +: 5];
            w_tuse = hz.D_tuse[TW*p +: TW];
            w_hit  = 1'b1;
            w_tn   = '0;
            w_sel  = 2'd0;
            if (hit(r_e_valid, r_e_dst, w_src)) begin
                w_tn  = r_e_tnew;
                w_sel = 2'd1;
            end else if (hit(r_m_valid, r_m_dst, w_src)) begin
                w_tn  = r_m_tnew;
                w_sel = 2'd2;
            end else if (hit(r_w_valid, r_w_dst, w_src)) begin
                w_tn  = r_w_tnew;
                w_sel = 2'd3;
            end else begin
                w_hit = 1'b0;
            end
            // a matched producer not yet ready (but early enough) leaves the
            // select at 0; the E-stage select picks it up one cycle later
            if (w_hit) begin
                if (w_tn > w_tuse)
                    w_stall_req[p] = 1'b1;
                else if (w_tn == '0)
                    w_d_fsel[2*p +: 2] = w_sel;
            end

            w_src = r_e_src[5*p +: 5];
            if (r_e_valid) begin
                if (hit(r_m_valid, r_m_dst, w_src)) begin
                    w_e_fsel[2*p +: 2] = 2'd2;
                    w_e_viol = w_e_viol | (r_m_tnew != '0);
                end else if (hit(r_w_valid, r_w_dst, w_src)) begin
                    w_e_fsel[2*p +: 2] = 2'd3;
                    w_e_viol = w_e_viol | (r_w_tnew != '0);
                end
            end
        end
    end

    // busy is forced low while reset is asserted so the outputs stay quiet
    assign w_md_busy  = reset_n & ((r_md_cnt != '0) | hz.E_md_start);
    assign hz.md_busy = w_md_busy;
    assign hz.stall   = hz.D_valid & ((|w_stall_req) | (hz.D_is_md & w_md_busy));
    assign hz.D_fsel  = w_d_fsel;
    assign hz.E_fsel  = w_e_fsel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e_valid <= 1'b0;
            r_e_dst   <= '0;
            r_e_tnew  <= '0;
            r_e_src   <= '0;
            r_m_valid <= 1'b0;
            r_m_dst   <= '0;
            r_m_tnew  <= '0;
            r_w_valid <= 1'b0;
            r_w_dst   <= '0;
            r_w_tnew  <= '0;
        end else begin
            if (hz.stall) begin
                r_e_valid <= 1'b0;
                r_e_dst   <= '0;
                r_e_tnew  <= '0;
                r_e_src   <= '0;
            end else begin
                r_e_valid <= hz.D_valid;
                r_e_dst   <= hz.D_dst;
                r_e_tnew  <= hz.D_tnew;
                r_e_src   <= hz.D_src;
            end
            r_m_valid <= r_e_valid;
            r_m_dst   <= r_e_dst;
            r_m_tnew  <= dec_sat(r_e_tnew);
            r_w_valid <= r_m_valid;
            r_w_dst   <= r_m_dst;
            r_w_tnew  <= dec_sat(r_m_tnew);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_md_cnt <= '0;
        else if (hz.E_md_start)
            r_md_cnt <= hz.E_md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        else if (r_md_cnt != '0)
            r_md_cnt <= r_md_cnt - 1'b1;
    end

`ifndef SYNTHESIS
    a_e_fwd_ready: assert property (@(posedge clk) disable iff (!reset_n) !w_e_viol);
`endif
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding-select and stall controller for the 5-stage pipeline (D/E/M/W).
- Keeps an internal shadow pipeline of producer records (dst, Tnew) and consumer records (src, Tuse).
- Generates per-port forward selects for D and E read ports plus a single D-stage stall.
- Adds a multi-cycle MDU busy tracker for mult/div interlock.

Parameters:
NREAD, 2, read ports per instruction (rs, rt, ...)
TW, 3, width of Tnew/Tuse fields
MULT_CYC, 5, MDU busy cycles for mult/multu
DIV_CYC, 10, MDU busy cycles for div/divu

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
D_valid  input  1  D holds a real instruction
D_src  input  NREAD*5  D source register numbers, port p at [5p+4:5p]
D_tuse  input  NREAD*TW  cycles after D entry at which port p value is needed
D_dst  input  5  D destination register (0 = none)
D_tnew  input  TW  cycles after E entry until result ready
D_is_md  input  1  D instruction uses MDU (mult/div/mfhi/mflo/mthi/mtlo)
E_md_start  input  1  E-stage mult/div issuing this cycle
E_md_is_div  input  1  qualifies E_md_start: 1 = div
stall  output  1  freeze PC and F/D, bubble into E
D_fsel  output  NREAD*2  D port select: 0 regfile, 1 E, 2 M, 3 W
E_fsel  output  NREAD*2  E port select: 0 E-latched value, 2 M, 3 W
md_busy  output  1  MDU busy

Behaviour:
- Reset (async, reset_n=0): E/M/W records invalid, Tnew=0, src=0; MDU counter=0. Hence stall=0, D_fsel=E_fsel=0, md_busy=0. Reset mid-stall or mid-MDU op aborts immediately.
- Record contents: valid, dst, tnew, NREAD src fields.
- Shift on posedge clk:
  - stall=0: E<=D (valid=D_valid), M<=E, W<=M.
  - stall=1: E<=bubble (valid=0, dst=0), M<=E, W<=M.
  - Tnew on E->M and M->W: saturating decrement (0 stays 0). Tnew loaded into E unchanged from D_tnew.
- Match rule: record s matches port p when valid, dst!=0, dst==src_p. Nearest stage wins: D ports E>M>W; E ports M>W. src_p=0 never matches -> select 0.
- D port p, nearest match s with Tnew_s:
  - Tnew_s > D_tuse_p: stall request.
  - Tnew_s == 0: D_fsel_p = s.
  - Otherwise D_fsel_p = 0; the E-stage select resolves it later.
- E port p: nearest match in M or W gives 2/3. Tnew of the matched record must be 0; nonzero is a design-rule violation, flagged by a simulation-only assertion.
- Stall = D_valid & (any D-port stall request | (D_is_md & md_busy)). Combinational, same cycle.
- MDU counter:
  - E_md_start loads MULT_CYC or DIV_CYC (load wins over decrement).
  - Otherwise nonzero counter decrements by 1 per cycle.
  - md_busy = (counter!=0) | E_md_start.
  - Start while busy reloads (last start wins).
- W-stage regfile write is not internally bypassed; same-cycle D read of a W dst must take D_fsel=3.
- All selects are combinational from current records and D inputs; no added latency.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> stall=0, all fsel=0, md_busy=0. Release -> E/M/W invalid.
- Load-use: E record dst=5 Tnew=2 (lw); D src0=5 Tuse=0 -> stall=1 for 2 cycles. Third cycle: W match Tnew=0 -> D_fsel[1:0]=3, stall=0.
- ALU chain: E dst=8 Tnew=1; D src1=8 Tuse=1 -> stall=0, D_fsel[3:2]=0. Next cycle (now M, Tnew=0): E_fsel[3:2]=2.
- Priority and $0: E dst=3 and M dst=3 both Tnew=0, D src0=3 -> D_fsel=1. D src0=0 with E dst=0 -> D_fsel=0, no stall.
- MDU: E_md_start=1, E_md_is_div=1; D_is_md=1 held -> stall=1 for 11 cycles (start cycle + 10), then 0. Mult case: 6 cycles.
- Bubble insertion: during stall, E record observed invalid next cycle; M/W continue advancing; D record enters E only after stall drops.
